// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle between the sequencer and alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       CTRL;
  logic [7:0]       FLAG_IN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT;
  logic [7:0]       FLAG_OUT;
  logic             BUSY;

  modport master (
    output IN_VALID, A, B, CTRL, FLAG_IN, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, FLAG_OUT, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, CTRL, FLAG_IN, OUT_READY,
    output IN_READY, OUT_VALID, OUT, FLAG_OUT, BUSY
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU; binary ops in one cycle, BCD ADC/SBC one digit per cycle
// Decimal mode and the DEC_RUN state exist only when ALU_DECIMAL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      CLK,
  input logic      RST,
  alu_seq_if.slave bus
);
  localparam logic [3:0] C_ALU_CTRL_THA = 4'h0;
  localparam logic [3:0] C_ALU_CTRL_AND = 4'h1;
  localparam logic [3:0] C_ALU_CTRL_ORA = 4'h2;
  localparam logic [3:0] C_ALU_CTRL_EOR = 4'h3;
  localparam logic [3:0] C_ALU_CTRL_ADC = 4'h4;
  localparam logic [3:0] C_ALU_CTRL_SBC = 4'h5;
  localparam logic [3:0] C_ALU_CTRL_CMP = 4'h6;
  localparam logic [3:0] C_ALU_CTRL_BIT = 4'h7;
  localparam logic [3:0] C_ALU_CTRL_INC = 4'h8;
  localparam logic [3:0] C_ALU_CTRL_DEC = 4'h9;
  localparam logic [3:0] C_ALU_CTRL_ASL = 4'hA;
  localparam logic [3:0] C_ALU_CTRL_LSR = 4'hB;
  localparam logic [3:0] C_ALU_CTRL_ROL = 4'hC;
  localparam logic [3:0] C_ALU_CTRL_ROR = 4'hD;

  localparam int C_FLAG_SHFT_C = 0;
  localparam int C_FLAG_SHFT_Z = 1;
  localparam int C_FLAG_SHFT_V = 6;
  localparam int C_FLAG_SHFT_N = 7;
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] out_q;
  logic [7:0]       flag_q;
  logic             out_valid_q;
  logic             busy;
  logic             is_dec;
  logic             in_ready;
  logic             accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   cmp;
  logic [WIDTH-1:0] bin_res;
  logic [7:0]       bin_flags;
  logic             set_nz;

  assign in_ready     = !busy && (!out_valid_q || bus.OUT_READY);
  assign accept       = bus.IN_VALID && in_ready;
  assign bus.IN_READY = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT      = out_q;
  assign bus.FLAG_OUT = flag_q;
  assign bus.BUSY     = busy;

  always_comb begin
    sum       = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.FLAG_IN[C_FLAG_SHFT_C]};
    diff      = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, bus.FLAG_IN[C_FLAG_SHFT_C]};
    cmp       = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
    bin_res   = bus.A;
    bin_flags = bus.FLAG_IN;
    set_nz    = 1'b1;
    case (bus.CTRL)
      C_ALU_CTRL_THA: set_nz = 1'b0;
      C_ALU_CTRL_AND: bin_res = bus.A & bus.B;
      C_ALU_CTRL_ORA: bin_res = bus.A | bus.B;
      C_ALU_CTRL_EOR: bin_res = bus.A ^ bus.B;
      C_ALU_CTRL_INC: bin_res = bus.A + {{(WIDTH-1){1'b0}}, 1'b1};
      C_ALU_CTRL_DEC: bin_res = bus.A - {{(WIDTH-1){1'b0}}, 1'b1};
      C_ALU_CTRL_ASL: begin
        bin_res = {bus.A[MSB-1:0], 1'b0};
        bin_flags[C_FLAG_SHFT_C] = bus.A[MSB];
      end
      C_ALU_CTRL_LSR: begin
        bin_res = {1'b0, bus.A[MSB:1]};
        bin_flags[C_FLAG_SHFT_C] = bus.A[0];
      end
      C_ALU_CTRL_ROL: begin
        bin_res = {bus.A[MSB-1:0], bus.FLAG_IN[C_FLAG_SHFT_C]};
        bin_flags[C_FLAG_SHFT_C] = bus.A[MSB];
      end
      C_ALU_CTRL_ROR: begin
        bin_res = {bus.FLAG_IN[C_FLAG_SHFT_C], bus.A[MSB:1]};
        bin_flags[C_FLAG_SHFT_C] = bus.A[0];
      end
      C_ALU_CTRL_ADC: begin
        bin_res = sum[MSB:0];
        bin_flags[C_FLAG_SHFT_C] = sum[WIDTH];
        bin_flags[C_FLAG_SHFT_V] = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
      end
      C_ALU_CTRL_SBC: begin
        bin_res = diff[MSB:0];
        bin_flags[C_FLAG_SHFT_C] = diff[WIDTH];
        bin_flags[C_FLAG_SHFT_V] = (bus.A[MSB] != bus.B[MSB]) && (diff[MSB] != bus.A[MSB]);
      end
      C_ALU_CTRL_CMP: begin
        set_nz = 1'b0;
        bin_flags[C_FLAG_SHFT_C] = cmp[WIDTH];
        bin_flags[C_FLAG_SHFT_Z] = (bus.A == bus.B);
        bin_flags[C_FLAG_SHFT_N] = cmp[MSB];
      end
      C_ALU_CTRL_BIT: begin
        set_nz = 1'b0;
        bin_flags[C_FLAG_SHFT_N] = bus.B[MSB];
        bin_flags[C_FLAG_SHFT_V] = bus.B[MSB-1];
        bin_flags[C_FLAG_SHFT_Z] = ((bus.A & bus.B) == '0);
      end
      default: bin_res = bus.A;
    endcase
    if (set_nz) begin
      bin_flags[C_FLAG_SHFT_N] = bin_res[MSB];
      bin_flags[C_FLAG_SHFT_Z] = (bin_res == '0);
    end
  end

`ifdef ALU_DECIMAL_EN
  localparam int C_FLAG_SHFT_D = 3;
  localparam int DIGITS = WIDTH / 4;
  localparam int KW = $clog2(DIGITS);
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic {IDLE, DEC_RUN} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] da_q, db_q, dres_q, dres_n;
  logic [7:0]       dflags_q, dec_flags;
  logic [KW-1:0]    k_q;
  logic             dsbc_q, dcy_q, dcy_n, dec_done;
  logic [4:0]       dsum;
  logic [3:0]       dig;

  assign busy     = (state_q == DEC_RUN);
  assign is_dec   = bus.FLAG_IN[C_FLAG_SHFT_D] &&
                    (bus.CTRL == C_ALU_CTRL_ADC || bus.CTRL == C_ALU_CTRL_SBC);
  assign dec_done = busy && (k_q == K_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_dec) state_d = DEC_RUN;
      DEC_RUN: if (k_q == K_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // dcy_q is a carry for ADC and a borrow for SBC
  always_comb begin
    if (dsbc_q) begin
      dsum  = {1'b0, da_q[3:0]} - {1'b0, db_q[3:0]} - {4'b0, dcy_q};
      dcy_n = dsum[4];
      dig   = dcy_n ? dsum[3:0] - 4'd6 : dsum[3:0];
    end else begin
      dsum  = {1'b0, da_q[3:0]} + {1'b0, db_q[3:0]} + {4'b0, dcy_q};
      dcy_n = (dsum > 5'd9);
      dig   = dcy_n ? dsum[3:0] + 4'd6 : dsum[3:0];
    end
    dres_n    = {dig, dres_q[WIDTH-1:4]};
    dec_flags = dflags_q;
    dec_flags[C_FLAG_SHFT_C] = dsbc_q ? !dcy_n : dcy_n;
    dec_flags[C_FLAG_SHFT_N] = dres_n[MSB];
    dec_flags[C_FLAG_SHFT_Z] = (dres_n == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      da_q     <= '0;
      db_q     <= '0;
      dres_q   <= '0;
      dflags_q <= '0;
      k_q      <= '0;
      dsbc_q   <= 1'b0;
      dcy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && is_dec) begin
        da_q     <= bus.A;
        db_q     <= bus.B;
        dres_q   <= '0;
        dflags_q <= bin_flags;
        k_q      <= '0;
        dsbc_q   <= (bus.CTRL == C_ALU_CTRL_SBC);
        dcy_q    <= (bus.CTRL == C_ALU_CTRL_SBC) ? !bus.FLAG_IN[C_FLAG_SHFT_C]
                                                 : bus.FLAG_IN[C_FLAG_SHFT_C];
      end else if (busy) begin
        da_q   <= da_q >> 4;
        db_q   <= db_q >> 4;
        dres_q <= dres_n;
        dcy_q  <= dcy_n;
        k_q    <= k_q + KW'(1);
      end
    end
  end
`else
  assign busy   = 1'b0;
  assign is_dec = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q       <= '0;
      flag_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (accept && !is_dec) begin
      out_q       <= bin_res;
      flag_q      <= bin_flags;
      out_valid_q <= 1'b1;
`ifdef ALU_DECIMAL_EN
    end else if (dec_done) begin
      out_q       <= dres_n;
      flag_q      <= dec_flags;
      out_valid_q <= 1'b1;
`endif
    end else if (bus.OUT_READY) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Supports operand width WIDTH. Binary ops complete in one cycle.
- Implements decimal-mode ADC/SBC (BCD, 65C02 flag semantics) nibble-serially, one digit per cycle.
- Sits between the CPU datapath sequencer and the register file. The sequencer stalls on IN_READY/OUT_VALID instead of assuming zero latency.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be a multiple of 4, range 8..32.
- DIGITS, WIDTH/4, derived local (not overridable): number of BCD digits.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operation request.
- IN_READY  output  1  block can accept a request this cycle.
- A  input  WIDTH  operand A (accumulator/register side).
- B  input  WIDTH  operand B (memory side).
- CTRL  input  4  op select; existing C_ALU_CTRL_* codes from params.vh.
- FLAG_IN  input  8  status register in, bit positions per C_FLAG_SHFT_*.
- OUT_VALID  output  1  result valid, held until accepted.
- OUT_READY  input  1  consumer accepts result.
- OUT  output  WIDTH  result.
- FLAG_OUT  output  8  status out. D, I, B and unused bits are copied from the captured FLAG_IN.
- BUSY  output  1  decimal iteration in progress.

Behaviour:
- Clocking and reset:
  - Single clock CLK; reset RST is synchronous, active-high.
  - Reset state: IDLE; OUT=0, FLAG_OUT=0, OUT_VALID=0, BUSY=0. IN_READY=1 from the first cycle after RST deasserts.
- Handshake:
  - IN_READY = !BUSY && (!OUT_VALID || OUT_READY).
  - A request is accepted at a rising edge where IN_VALID && IN_READY. A, B, CTRL and FLAG_IN are captured then; the inputs may change afterwards.
  - OUT_VALID clears on an edge with OUT_READY=1 unless a new result is produced on that same edge. Back-to-back binary ops give one result per cycle.
  - OUT and FLAG_OUT stay stable while OUT_VALID=1 && OUT_READY=0.
- States:
  - IDLE: waiting for a request.
  - DEC_RUN: digit index k counts 0..DIGITS-1.
  - Binary op or CMP/BIT/THA accepted: result and flags are registered on the accepting edge, so OUT_VALID=1 the next cycle (latency 1). State stays IDLE.
  - ADC/SBC with D=1 accepted: go to DEC_RUN, BUSY=1, carry register loaded from C. Each edge processes digit k (LSB first) and shifts it into the result.
  - On the edge processing k=DIGITS-1: go to IDLE, BUSY=0, OUT_VALID=1. Latency is DIGITS+1 edges from acceptance.
- Binary ops, all on WIDTH bits; MSB means bit WIDTH-1:
  - Unless an op states otherwise, N = result MSB and Z = (result==0).
  - THA: OUT=A; all flags unchanged.
  - AND, ORA, EOR: logical op; C and V unchanged.
  - INC, DEC: A±1 modulo 2^WIDTH; C and V unchanged.
  - ASL, LSR: shift by one, shifted-out bit goes to C.
  - ROL, ROR: rotate by one through C.
  - ADC: A+B+C. C = carry-out. V = signed overflow.
  - SBC: A-B-(1-C). C = no-borrow. V = signed overflow.
  - CMP: OUT=A. Flags from A-B: C=(A>=B unsigned), Z=(A==B), N=MSB of the difference.
  - BIT: OUT=A; N=B[WIDTH-1], V=B[WIDTH-2], Z=((A&B)==0).
  - Undefined CTRL: OUT=A; N and Z from A.
- Decimal digits:
  - ADC: s = a+b+c. If s>9: s=s+6 and c=1, else c=0. The digit is s[3:0].
  - SBC: borrow starts as !C. d = a-b-borrow. If d<0: d=d-6 (mod 16) and borrow=1, else borrow=0.
  - Non-BCD digits are processed by the same rule, no trap.
- Decimal flags:
  - C = final carry (ADC) or !final borrow (SBC).
  - N and Z come from the decimal result.
  - V is the binary-mode V for the same operands.
- Reset mid-operation: RST in any state aborts, discards the partial result and applies reset values on that edge.
- IN_VALID while BUSY or stalled is ignored, not queued.

Optional Feature:
- Macro: ALU_DECIMAL_EN.
- When defined: decimal ADC/SBC and the DEC_RUN state exist, as above.
- When undefined: FLAG_IN D bit is ignored for arithmetic. ADC/SBC are always binary with latency 1. BUSY is tied 0 and there is no DEC_RUN state. D is still passed through to FLAG_OUT.

Test Plan:
- Reset: RST high 2 cycles mid-stream -> OUT=0, FLAG_OUT=0, OUT_VALID=0, BUSY=0; IN_READY=1 the cycle after release.
- Binary ADC, WIDTH=8: A=0x50, B=0x50, C=0, D=0 -> OUT=0xA0, N=1, V=1, Z=0, C=0, OUT_VALID one cycle after acceptance. SBC A=0x00, B=0x01, C=1 -> OUT=0xFF, C=0, N=1.
- Decimal, ALU_DECIMAL_EN, WIDTH=8:
  - ADC A=0x58, B=0x46, C=1, D=1 -> OUT=0x05, C=1, Z=0; BUSY=1 for 2 cycles; OUT_VALID 3 edges after acceptance.
  - SBC A=0x12, B=0x21, C=1 -> OUT=0x91, C=0, N=1.
- WIDTH=16 decimal: ADC 0x9999 + 0x0001, C=0 -> OUT=0x0000, C=1, Z=1, latency 5. Same op without ALU_DECIMAL_EN -> OUT=0x999A, C=0, latency 1.
- Backpressure: CMP A=0x10, B=0x10 with OUT_READY=0 for 4 cycles -> Z=1, C=1, N=0, OUT=0x10 held stable, IN_READY=0. New IN_VALID ignored until OUT_READY=1.
- Abort: RST asserted on the second DEC_RUN cycle -> next cycle IDLE, OUT_VALID=0, OUT=0. A following binary AND 0xF0&0x0F -> OUT=0x00, Z=1.
